bram_load_adapter: RTL and testbench
====================================

BRAM_LOAD_ADAPTER -- requirements
Module: bram_load_adapter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 44: internal element width, range 1..128.
REQ-002 The block SHALL have parameter DEPTH, default 16: element count of internal memory.
REQ-003 The block SHALL have derived localparams: BEATS = ceil(DATA_WIDTH/32); BEAT_W = max(1, clog2(BEATS)); ADDR_W = clog2(DEPTH); BYTE_ADDR_W = ADDR_W + BEAT_W + 2.
REQ-004 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port load_start, input, 1: single-cycle pulse that arms a new load.
REQ-007 The block SHALL have port load_len, input, ADDR_W+1: element count expected, sampled on load_start.
REQ-008 The block SHALL have ports s_din, input, 32; s_ena, input, 1; s_wea, input, 1; s_addra, input, BYTE_ADDR_W: host byte-addressed write beat.
REQ-009 The block SHALL have ports s_addrb, input, BYTE_ADDR_W; s_doutb, output, 32: host read-back.
REQ-010 The block SHALL have ports rd_en, input, 1; rd_addr, input, ADDR_W; rd_dout, output, DATA_WIDTH; rd_valid, output, 1: compute-side read.
REQ-011 The block SHALL have outputs load_done, 1; seq_err, 1; range_err, 1; ovf_err, 1; load_cnt, ADDR_W+1.

Function
REQ-012 The block SHALL have FSM states IDLE, LOAD, DONE. Transitions: IDLE/LOAD/DONE -> LOAD on load_start; LOAD -> DONE when load_cnt reaches the latched load_len; load_start with load_len=0 -> DONE next cycle.
REQ-013 On load_start the block SHALL clear load_cnt, all error flags and the assembly state; a write beat in the same cycle SHALL be dropped.
REQ-014 A write beat SHALL be s_ena & s_wea; s_addra[1:0] ignored; beat index = s_addra[BEAT_W+1:2]; element index = s_addra[BYTE_ADDR_W-1:BEAT_W+2].
REQ-015 Beats SHALL arrive in order 0..BEATS-1 for one element. Beat 0 starts assembly. Any other beat whose index or element index mismatches expectation SHALL set seq_err (sticky) and discard the assembly.
REQ-016 On beat BEATS-1 the block SHALL write {current beat, held beats} truncated to DATA_WIDTH bits into memory at the element index in the same cycle, and SHALL increment load_cnt. BEATS=1 commits every beat.
REQ-017 An element index >= DEPTH SHALL set range_err (sticky); the beat SHALL be dropped and not counted.
REQ-018 A write beat in IDLE or DONE SHALL set ovf_err (sticky) and be dropped.
REQ-019 load_done SHALL be 1 exactly while in DONE; errors SHALL NOT block the transition to DONE.
REQ-020 rd_dout/rd_valid SHALL appear 1 cycle after rd_en; rd_valid=0 otherwise; rd_dout SHALL hold its last value.
REQ-021 s_doutb SHALL return 32-bit slice [beat*32 +: 32] of the element, zero-extended beyond DATA_WIDTH, with 2-cycle latency, continuously addressed.
REQ-022 A read of an address written in the same cycle SHALL return old data (read-first).
REQ-023 Reads SHALL be legal in all states; out-of-range read addresses SHALL return 0.

Reset
REQ-024 On rst_n=0 the block SHALL enter IDLE and set load_done, load_cnt, seq_err, range_err, ovf_err, rd_valid, rd_dout and s_doutb to 0, and clear the assembly state.
REQ-025 Memory contents SHALL NOT be reset. Reset mid-load SHALL abandon the load; the host must reissue load_start.

Structure
REQ-026 The shared package gat_pkg SHALL contain the constant BUS_W=32 and the adapter FSM state enum.
REQ-027 Storage SHALL be one sub-module bram_sdp: one write port and two registered read ports, parameterised by width and depth, inferring block RAM.

Verification
REQ-028 The bench SHALL cover these cases, with DATA_WIDTH=44, DEPTH=16:
- load_start, load_len=2; writes: addr 0x00=0x89ABCDEF, 0x04=0x00000123, 0x08=0x11111111, 0x0C=0x00000FFF -> load_cnt=2, load_done=1 on the next cycle; rd_addr=0 gives 0x12389ABCDEF with rd_valid one cycle later.
- Beat 1 (0x04) sent without beat 0 -> seq_err=1, load_cnt=0, memory unchanged.
- Write to element 16 (addr 0x80) -> range_err=1, dropped, load_cnt unchanged.
- Write after DONE -> ovf_err=1; memory unchanged. New load_start -> all flags 0, state LOAD.
- s_addrb=0x04 after the first case -> s_doutb=0x00000123 two cycles later.
- rst_n pulsed low after one beat of element 0 -> all outputs 0, state IDLE; a following load_start plus full element 0 completes correctly.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared constants and types for the BRAM load adapter.
// Latency: none (declarations only). Backpressure: none.
// Host bus width and the adapter load-state encoding.
package gat_pkg;

   localparam int BUS_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } adapter_state_t;

endpackage

// File: rtl/bram_sdp.sv
// Block RAM with one write port and two registered read-first read ports.
// Latency: 1 cycle on each read port. Backpressure: none.
// Out-of-range read addresses return zero; contents are never reset.
module bram_sdp #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Non-blocking reads of mem give read-first behaviour on a same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (re_a) begin
            rdata_a <= (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
         end
         rdata_b <= (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;
      end
   end

endmodule

// File: rtl/bram_load_adapter.sv
// Assembles 32-bit host write beats into DATA_WIDTH elements and loads them into block RAM.
// Latency: element committed on its last beat; rd_dout 1 cycle, s_doutb 2 cycles.
// Backpressure: none; illegal beats are dropped and flagged by sticky error bits.
module bram_load_adapter
   import gat_pkg::*;
#(
   parameter int DATA_WIDTH = 44,
   parameter int DEPTH      = 16,
   localparam int BEATS       = (DATA_WIDTH + BUS_W - 1) / BUS_W,
   localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int ADDR_W      = $clog2(DEPTH),
   localparam int BYTE_ADDR_W = ADDR_W + BEAT_W + 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic [ADDR_W:0]        load_len,
   input  logic [31:0]            s_din,
   input  logic                   s_ena,
   input  logic                   s_wea,
   input  logic [BYTE_ADDR_W-1:0] s_addra,
   input  logic [BYTE_ADDR_W-1:0] s_addrb,
   output logic [31:0]            s_doutb,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0]  rd_dout,
   output logic                   rd_valid,
   output logic                   load_done,
   output logic                   seq_err,
   output logic                   range_err,
   output logic                   ovf_err,
   output logic [ADDR_W:0]        load_cnt
);

   adapter_state_t state;

   logic                     wr_beat;
   logic [BEAT_W-1:0]        b_idx;
   logic [ADDR_W-1:0]        e_idx;
   logic                     in_range;
   logic                     seq_ok;
   logic                     commit;
   logic                     mem_we;
   logic [ADDR_W:0]          len_q;
   logic [ADDR_W:0]          cnt_inc;
   logic                     asm_vld;
   logic [ADDR_W-1:0]        asm_elem;
   logic [BEAT_W-1:0]        asm_beat;
   logic [BEATS*BUS_W-1:0]   hold;
   logic [BEATS*BUS_W-1:0]   wr_word;
   logic [DATA_WIDTH-1:0]    rb_elem;
   logic [BEATS*BUS_W-1:0]   rb_pad;
   logic [BEAT_W-1:0]        rb_beat;
   logic                     unused_bits;

   assign wr_beat  = s_ena & s_wea;
   assign b_idx    = s_addra[BEAT_W+1:2];
   assign e_idx    = s_addra[BYTE_ADDR_W-1:BEAT_W+2];
   assign in_range = int'(e_idx) < DEPTH;
   assign cnt_inc  = load_cnt + 1'b1;

   // Beat 0 always (re)starts an element; later beats must continue the open one.
   always_comb begin
      seq_ok = (b_idx == '0) ||
               (asm_vld && (b_idx == asm_beat) && (e_idx == asm_elem));
      commit = seq_ok && (b_idx == BEAT_W'(BEATS - 1));
      mem_we = wr_beat && (state == LOAD) && !load_start && in_range && commit;
   end

   always_comb begin
      wr_word = hold;
      wr_word[(BEATS-1)*BUS_W +: BUS_W] = s_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         load_done <= 1'b0;
         load_cnt  <= '0;
         len_q     <= '0;
         seq_err   <= 1'b0;
         range_err <= 1'b0;
         ovf_err   <= 1'b0;
         asm_vld   <= 1'b0;
         asm_elem  <= '0;
         asm_beat  <= '0;
         hold      <= '0;
      end else if (load_start) begin
         state     <= (load_len == '0) ? DONE : LOAD;
         load_done <= (load_len == '0);
         load_cnt  <= '0;
         len_q     <= load_len;
         seq_err   <= 1'b0;
         range_err <= 1'b0;
         ovf_err   <= 1'b0;
         asm_vld   <= 1'b0;
         asm_elem  <= '0;
         asm_beat  <= '0;
         hold      <= '0;
      end else if (wr_beat) begin
         if (state != LOAD) begin
            ovf_err <= 1'b1;
         end else if (!in_range) begin
            range_err <= 1'b1;
         end else if (!seq_ok) begin
            seq_err <= 1'b1;
            asm_vld <= 1'b0;
         end else if (commit) begin
            asm_vld  <= 1'b0;
            load_cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
               state     <= DONE;
               load_done <= 1'b1;
            end
         end else begin
            asm_vld  <= 1'b1;
            asm_elem <= e_idx;
            asm_beat <= b_idx + 1'b1;
            hold[int'(b_idx)*BUS_W +: BUS_W] <= s_din;
         end
      end
   end

   bram_sdp #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (mem_we),
      .waddr   (e_idx),
      .wdata   (wr_word[DATA_WIDTH-1:0]),
      .re_a    (rd_en),
      .raddr_a (rd_addr),
      .rdata_a (rd_dout),
      .raddr_b (s_addrb[BYTE_ADDR_W-1:BEAT_W+2]),
      .rdata_b (rb_elem)
   );

   always_comb begin
      rb_pad = '0;
      rb_pad[DATA_WIDTH-1:0] = rb_elem;
   end

   // Host read-back: RAM stage, then beat-slice stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rb_beat  <= '0;
         s_doutb  <= '0;
      end else begin
         rd_valid <= rd_en;
         rb_beat  <= s_addrb[BEAT_W+1:2];
         s_doutb  <= (int'(rb_beat) < BEATS) ? rb_pad[int'(rb_beat)*BUS_W +: BUS_W] : '0;
      end
   end

   assign unused_bits = &{1'b0, s_addra[1:0], s_addrb[1:0], wr_word};

endmodule

// File: tb/tb_bram_load_adapter.sv
// Bench for bram_load_adapter (44-bit elements, 16 deep) with a behavioural model and directed cases.
// A second 12-deep instance shares all inputs so that an out-of-range element is encodable.
module tb_bram_load_adapter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic [4:0]  load_len = '0;
   logic [31:0] s_din = '0;
   logic        s_ena = 1'b0;
   logic        s_wea = 1'b0;
   logic [6:0]  s_addra = '0;
   logic [6:0]  s_addrb = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] s_doutb;
   logic [43:0] rd_dout;
   logic        rd_valid, load_done, seq_err, range_err, ovf_err;
   logic [4:0]  load_cnt;

   logic [31:0] r_s_doutb;
   logic [43:0] r_rd_dout;
   logic        r_rd_valid, r_load_done, r_seq_err, r_range_err, r_ovf_err;
   logic [4:0]  r_load_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bram_load_adapter #(.DATA_WIDTH(44), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
      .s_din(s_din), .s_ena(s_ena), .s_wea(s_wea), .s_addra(s_addra),
      .s_addrb(s_addrb), .s_doutb(s_doutb),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_valid(rd_valid),
      .load_done(load_done), .seq_err(seq_err), .range_err(range_err),
      .ovf_err(ovf_err), .load_cnt(load_cnt)
   );

   bram_load_adapter #(.DATA_WIDTH(44), .DEPTH(12)) dut_r (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
      .s_din(s_din), .s_ena(s_ena), .s_wea(s_wea), .s_addra(s_addra),
      .s_addrb(s_addrb), .s_doutb(r_s_doutb),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(r_rd_dout), .rd_valid(r_rd_valid),
      .load_done(r_load_done), .seq_err(r_seq_err), .range_err(r_range_err),
      .ovf_err(r_ovf_err), .load_cnt(r_load_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model of the 16-deep instance: two 32-bit beats per 44-bit element.
   logic [43:0] m_mem [16];
   bit          m_known [16];
   bit          m_loading, m_done, m_seq, m_rng, m_ovf;
   int          m_cnt, m_len;
   bit          m_pend;
   int          m_pend_elem;
   logic [31:0] m_lo;
   logic [43:0] e_rd_dout;
   bit          e_rd_known, e_rd_valid;
   logic [31:0] e_db1, e_db2;
   bit          e_db1_k, e_db2_k;

   initial begin
      for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin : model
      int e;
      int b;
      logic [63:0] w;
      if (!rst_n) begin
         m_loading = 0; m_done = 0; m_seq = 0; m_rng = 0; m_ovf = 0;
         m_cnt = 0; m_len = 0; m_pend = 0;
         e_rd_dout = '0; e_rd_known = 1; e_rd_valid = 0;
         e_db1 = '0; e_db2 = '0; e_db1_k = 1; e_db2_k = 1;
      end else begin
         // reads observe memory as it was before this edge's write
         if (rd_en) begin
            e_rd_dout  = m_mem[rd_addr];
            e_rd_known = m_known[rd_addr];
         end
         e_rd_valid = rd_en;
         e_db2   = e_db1;
         e_db2_k = e_db1_k;
         e = int'(s_addrb) / 8;
         b = (int'(s_addrb) / 4) % 2;
         w = {20'b0, m_mem[e]} >> (32 * b);
         e_db1   = w[31:0];
         e_db1_k = m_known[e];

         e = int'(s_addra) / 8;
         b = (int'(s_addra) / 4) % 2;
         if (load_start) begin
            m_len = int'(load_len); m_cnt = 0;
            m_done = (load_len == 0); m_loading = !m_done;
            m_seq = 0; m_rng = 0; m_ovf = 0; m_pend = 0;
         end else if (s_ena && s_wea) begin
            if (!m_loading) begin
               m_ovf = 1;
            end else if (b == 0) begin
               m_pend = 1; m_pend_elem = e; m_lo = s_din;
            end else if (m_pend && m_pend_elem == e) begin
               m_mem[e] = {s_din[11:0], m_lo};
               m_known[e] = 1;
               m_cnt++;
               m_pend = 0;
               if (m_cnt == m_len) begin
                  m_loading = 0; m_done = 1;
               end
            end else begin
               m_seq = 1; m_pend = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_load_done", 64'(load_done), 64'(m_done));
         check("mdl_load_cnt", 64'(load_cnt), 64'(m_cnt));
         check("mdl_seq_err", 64'(seq_err), 64'(m_seq));
         check("mdl_range_err", 64'(range_err), 64'(m_rng));
         check("mdl_ovf_err", 64'(ovf_err), 64'(m_ovf));
         check("mdl_rd_valid", 64'(rd_valid), 64'(e_rd_valid));
         if (e_rd_known) check("mdl_rd_dout", 64'(rd_dout), 64'(e_rd_dout));
         if (e_db2_k) check("mdl_s_doutb", 64'(s_doutb), 64'(e_db2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [4:0] len);
      load_start = 1'b1; load_len = len;
      tick();
      load_start = 1'b0;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      s_ena = 1'b1; s_wea = 1'b1; s_addra = a; s_din = d;
      tick();
      s_ena = 1'b0; s_wea = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_load_done"}, 64'(load_done), 64'd0);
      check({tag, "_load_cnt"}, 64'(load_cnt), 64'd0);
      check({tag, "_seq_err"}, 64'(seq_err), 64'd0);
      check({tag, "_range_err"}, 64'(range_err), 64'd0);
      check({tag, "_ovf_err"}, 64'(ovf_err), 64'd0);
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      check({tag, "_rd_dout"}, 64'(rd_dout), 64'd0);
      check({tag, "_s_doutb"}, 64'(s_doutb), 64'd0);
   endtask

   initial begin
      tick(); tick();
      chk_en = 1'b1;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // two-element load
      start(5'd2);
      check("load_busy", 64'(load_done), 64'd0);
      wr(7'h00, 32'h89ABCDEF);
      wr(7'h04, 32'h00000123);
      check("cnt_after_e0", 64'(load_cnt), 64'd1);
      wr(7'h08, 32'h11111111);
      check("done_mid", 64'(load_done), 64'd0);
      wr(7'h0C, 32'h00000FFF);
      check("cnt_after_e1", 64'(load_cnt), 64'd2);
      check("done_after_e1", 64'(load_done), 64'd1);
      check("model_elem0", 64'(m_mem[0]), 64'h12389ABCDEF);
      rd(4'd0);
      check("rd_valid_1", 64'(rd_valid), 64'd1);
      check("rd_elem0", 64'(rd_dout), 64'h12389ABCDEF);
      tick();
      check("rd_valid_0", 64'(rd_valid), 64'd0);
      check("rd_hold", 64'(rd_dout), 64'h12389ABCDEF);

      // host read-back latency and zero extension
      s_addrb = 7'h04;
      tick();
      check("doutb_lat1", 64'(s_doutb), 64'h89ABCDEF);
      tick();
      check("doutb_lat2", 64'(s_doutb), 64'h00000123);
      s_addrb = 7'h0C;
      tick(); tick();
      check("doutb_zext", 64'(s_doutb), 64'h00000FFF);

      // write after DONE
      wr(7'h00, 32'hDEADBEEF);
      check("ovf_done", 64'(ovf_err), 64'd1);
      rd(4'd0);
      check("ovf_mem_kept", 64'(rd_dout), 64'h12389ABCDEF);

      // new load clears flags
      start(5'd1);
      check("restart_ovf", 64'(ovf_err), 64'd0);
      check("restart_done", 64'(load_done), 64'd0);

      // beat 1 without beat 0
      wr(7'h04, 32'h00000555);
      check("seq_err_set", 64'(seq_err), 64'd1);
      check("seq_cnt", 64'(load_cnt), 64'd0);
      rd(4'd0);
      check("seq_mem_kept", 64'(rd_dout), 64'h12389ABCDEF);
      wr(7'h10, 32'hCAFEF00D);
      wr(7'h14, 32'h00000ABC);
      check("seq_then_done", 64'(load_done), 64'd1);
      check("seq_sticky", 64'(seq_err), 64'd1);

      // beat 1 for a different element than the open beat 0
      start(5'd2);
      wr(7'h18, 32'h00000001);
      wr(7'h24, 32'h00000002);
      check("seq_elem_mismatch", 64'(seq_err), 64'd1);
      check("seq_elem_cnt", 64'(load_cnt), 64'd0);

      // element 12 is out of range on the 12-deep instance only
      wr(7'h60, 32'h00000001);
      check("range_set", 64'(r_range_err), 64'd1);
      check("range_cnt", 64'(r_load_cnt), 64'd0);
      check("range_main_clear", 64'(range_err), 64'd0);
      wr(7'h64, 32'h00000002);
      check("range_b1_cnt", 64'(r_load_cnt), 64'd0);
      check("range_main_cnt", 64'(load_cnt), 64'd1);
      wr(7'h58, 32'h00000003);
      wr(7'h5C, 32'h00000004);
      check("range_r_cnt", 64'(r_load_cnt), 64'd1);
      check("range_r_done", 64'(r_load_done), 64'd0);
      check("range_main_done", 64'(load_done), 64'd1);

      // read-first on a same-cycle commit
      start(5'd1);
      wr(7'h10, 32'h11223344);
      rd_en = 1'b1; rd_addr = 4'd2;
      wr(7'h14, 32'h00000055);
      rd_en = 1'b0;
      check("rf_old", 64'(rd_dout), 64'hABCCAFEF00D);
      rd(4'd2);
      check("rf_new", 64'(rd_dout), 64'h05511223344);

      // zero-length load
      start(5'd0);
      check("len0_done", 64'(load_done), 64'd1);
      check("len0_cnt", 64'(load_cnt), 64'd0);

      // reset in the middle of an element
      start(5'd1);
      wr(7'h00, 32'hAAAA5555);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      wr(7'h00, 32'h00000001);
      check("idle_ovf", 64'(ovf_err), 64'd1);
      start(5'd1);
      wr(7'h00, 32'h13579BDF);
      wr(7'h04, 32'h00002468);
      check("reload_done", 64'(load_done), 64'd1);
      check("reload_cnt", 64'(load_cnt), 64'd1);
      check("reload_seq", 64'(seq_err), 64'd0);
      rd(4'd0);
      check("reload_elem0", 64'(rd_dout), 64'h46813579BDF);

      tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
